serial_divider: RTL and testbench

//  Multi-cycle restoring divider executing DIV/IDIV, the inverse of the combinational MUL/IMUL path.

---
 rtl/serial_divider.sv | 165 ++++++++++++++++
 tb/tb_serial_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// Multi-cycle restoring divider for DIV/IDIV: one quotient bit per clock,
// with divide-error detection (zero divisor, quotient overflow).
module serial_divider #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      is_8_bit,
  input  logic                      is_signed,
  input  logic [2*DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH-1:0]     divisor,
  output logic [DATA_WIDTH-1:0]     quotient,
  output logic [DATA_WIDTH-1:0]     remainder,
  output logic                      busy,
  output logic                      complete,
  output logic                      error
);
  localparam int W = DATA_WIDTH;
  localparam int H = DATA_WIDTH / 2;
  localparam logic [2*W-1:0] ONE_L = 1;
  localparam logic [W-1:0]   ONE_S = 1;
  localparam logic [W-1:0]   LIM_8  = W'(2**(H-1) - 1);
  localparam logic [W-1:0]   LIM_16 = W'(2**(W-1) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIXUP} state_t;

  function automatic logic [2*W-1:0] cneg_l(input logic [2*W-1:0] v, input logic n);
    cneg_l = n ? (~v + ONE_L) : v;
  endfunction

  function automatic logic [W-1:0] cneg_s(input logic [W-1:0] v, input logic n);
    cneg_s = n ? (~v + ONE_S) : v;
  endfunction

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [W-1:0]    qout_q, qout_d, rout_q, rout_d;
  logic            is8_q, is8_d, sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d;
  logic [2*W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d, dmag_q, dmag_d, qsh_q, qsh_d;
  logic [W:0]      rem_q, rem_d;

  logic [2*W-1:0]  dvd_ext, mag_dvd;
  logic [W-1:0]    dvs_ext, mag_dvs_full, mag_dvs, hi_mag, lo_mag, lim, qn, rn, q_fix, r_fix;
  logic [W:0]      shifted, diff;
  logic            sd, ss, no_borrow, fix_err, load_err;
  logic [4:0]      last_cnt;

  // Magnitudes of the captured operands; 8-bit mode works in the low half.
  always_comb begin
    sd           = is8_q ? dvd_q[W-1] : dvd_q[2*W-1];
    ss           = is8_q ? dvs_q[H-1] : dvs_q[W-1];
    dvd_ext      = is8_q ? {{W{dvd_q[W-1]}}, dvd_q[W-1:0]} : dvd_q;
    mag_dvd      = cneg_l(dvd_ext, sgn_q & sd);
    dvs_ext      = is8_q ? {{H{dvs_q[H-1]}}, dvs_q[H-1:0]} : dvs_q;
    mag_dvs_full = cneg_s(dvs_ext, sgn_q & ss);
    mag_dvs      = is8_q ? {{H{1'b0}}, mag_dvs_full[H-1:0]} : mag_dvs_full;
    hi_mag       = is8_q ? {{H{1'b0}}, mag_dvd[W-1:H]} : mag_dvd[2*W-1:W];
    lo_mag       = is8_q ? {mag_dvd[H-1:0], {H{1'b0}}} : mag_dvd[W-1:0];
    load_err     = (mag_dvs == '0) || (hi_mag >= mag_dvs);
    shifted      = {rem_q[W-1:0], qsh_q[W-1]};
    diff         = shifted - {1'b0, dmag_q};
    no_borrow    = shifted >= {1'b0, dmag_q};
    last_cnt     = is8_q ? 5'(H - 1) : 5'(W - 1);
    lim          = is8_q ? LIM_8 : LIM_16;
    fix_err      = sgn_q && (qsh_q > lim);
    qn           = cneg_s(qsh_q, negq_q);
    rn           = cneg_s(rem_q[W-1:0], negr_q);
    q_fix        = is8_q ? {{H{1'b0}}, qn[H-1:0]} : qn;
    r_fix        = is8_q ? {{H{1'b0}}, rn[H-1:0]} : rn;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qout_d   = qout_q;
    rout_d   = rout_q;
    is8_d    = is8_q;
    sgn_d    = sgn_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    dmag_d   = dmag_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    rem_d    = rem_q;
    qsh_d    = qsh_q;
    complete = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          is8_d   = is_8_bit;
          sgn_d   = is_signed;
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = LOAD;
        end
      end
      LOAD: begin
        dmag_d = mag_dvs;
        rem_d  = {1'b0, hi_mag};
        qsh_d  = lo_mag;
        cnt_d  = '0;
        negq_d = sgn_q & (sd ^ ss);
        negr_d = sgn_q & sd;
        if (load_err) begin
          complete = 1'b1;
          error    = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = ITER;
        end
      end
      ITER: begin
        rem_d = no_borrow ? diff : shifted;
        qsh_d = {qsh_q[W-2:0], no_borrow};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == last_cnt) state_d = FIXUP;
      end
      FIXUP: begin
        complete = 1'b1;
        if (fix_err) begin
          error  = 1'b1;
        end else begin
          qout_d = q_fix;
          rout_d = r_fix;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Results are presented combinationally in the completion cycle, then held.
  assign quotient  = (state_q == FIXUP && !fix_err) ? q_fix : qout_q;
  assign remainder = (state_q == FIXUP && !fix_err) ? r_fix : rout_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qout_q  <= '0;
      rout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
    end
  end

  always_ff @(posedge clk) begin
    is8_q  <= is8_d;
    sgn_q  <= sgn_d;
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    dmag_q <= dmag_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
    rem_q  <= rem_d;
    qsh_q  <= qsh_d;
  end
endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider: arithmetic reference model, randomized
// and directed operations, reset-abort and start-while-busy scenarios.
module tb_serial_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_8_bit = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient, remainder;
  logic        busy, complete, error;

  serial_divider #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .is_8_bit(is_8_bit),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy),
    .complete(complete), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          nvec = 0;
  int          nfail = 0;
  logic [15:0] last_q = '0;
  logic [15:0] last_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, 8086 result ranges.
  task automatic model(input bit is8, input bit sgn, input logic [31:0] dvd,
                       input logic [15:0] dvs, output logic [15:0] q,
                       output logic [15:0] r, output bit err, output int lat);
    longint a, b, qq, rr, aa, bb, mask;
    int n;
    n = is8 ? 8 : 16;
    mask = (longint'(1) << n) - 1;
    if (is8) begin
      if (sgn) begin a = longint'($signed(dvd[15:0])); b = longint'($signed(dvs[7:0])); end
      else     begin a = longint'(dvd[15:0]);          b = longint'(dvs[7:0]); end
    end else begin
      if (sgn) begin a = longint'($signed(dvd));       b = longint'($signed(dvs)); end
      else     begin a = longint'(dvd);                b = longint'(dvs); end
    end
    q = '0; r = '0;
    if (b == 0) begin
      err = 1'b1; lat = 1;
    end else begin
      qq = a / b;
      rr = a % b;
      aa = (a < 0) ? -a : a;
      bb = (b < 0) ? -b : b;
      if (sgn) err = (qq > (mask >> 1)) || (qq < -(mask >> 1));
      else     err = (qq > mask);
      lat = (err && ((aa >> n) >= bb)) ? 1 : n + 2;
      q = 16'(qq & mask);
      r = 16'(rr & mask);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input bit is8, input bit sgn, input logic [31:0] dvd,
                       input logic [15:0] dvs, input bit track);
    logic [15:0] q, r;
    bit err;
    int lat;
    exp_t e;
    wait_idle();
    model(is8, sgn, dvd, dvs, q, r, err, lat);
    if (err) begin q = last_q; r = last_r; end
    else if (track) begin last_q = q; last_r = r; end
    is_8_bit = is8; is_signed = sgn; dividend = dvd; divisor = dvs;
    start = 1'b1;
    if (track) begin
      e.q = q; e.r = r; e.err = err; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    is_8_bit = 1'($urandom_range(0, 1)); is_signed = 1'($urandom_range(0, 1));
    dividend = $urandom; divisor = 16'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!reset && complete) begin
      if (sb.size() == 0) begin
        chk("unexpected_complete", 32'(complete), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("error", 32'(error), 32'(e.err));
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          is8, sgn;
    logic [31:0] dvd;
    logic [15:0] dvs;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_complete", 32'(complete), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_q", 32'(quotient), 32'd0);
    chk("reset_r", 32'(remainder), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(0, 0, 32'h0001_0000, 16'h0003, 1);
    wait_idle(); @(negedge clk);
    chk("div16_q", 32'(quotient), 32'h5555);
    chk("div16_r", 32'(remainder), 32'h0001);
    issue(1, 0, 32'hABCD_0064, 16'h1207, 1);
    wait_idle(); @(negedge clk);
    chk("div8_q", 32'(quotient), 32'h000E);
    chk("div8_r", 32'(remainder), 32'h0002);
    issue(0, 1, 32'hFFFF_FFF9, 16'h0002, 1);
    wait_idle(); @(negedge clk);
    chk("idiv16_q", 32'(quotient), 32'hFFFD);
    chk("idiv16_r", 32'(remainder), 32'hFFFF);
    issue(1, 1, 32'h0000_0007, 16'h00FE, 1);
    issue(0, 0, 32'h1234_5678, 16'h0000, 1);
    issue(1, 1, 32'h0000_1234, 16'hFF00, 1);
    issue(0, 0, 32'h0003_0000, 16'h0002, 1);
    issue(1, 1, 32'h0000_FF00, 16'h0002, 1);
    issue(0, 1, 32'h0000_8000, 16'hFFFF, 1);
    issue(0, 1, 32'hFFFF_8000, 16'h0001, 1);
    issue(1, 1, 32'h0000_FF81, 16'h0001, 1);
    issue(0, 0, 32'hFFFE_FFFF, 16'hFFFF, 1);
    wait_idle(); @(negedge clk);
    chk("err_hold_q", 32'(quotient), 32'(last_q));

    // Start held while busy: only the first operation may complete.
    issue(0, 0, 32'h0000_9C40, 16'h0007, 1);
    for (int i = 0; i < 40; i++) begin
      if (complete || !busy) break;
      start = 1'b1; dividend = $urandom; divisor = 16'($urandom | 1);
      @(negedge clk);
    end
    start = 1'b0;
    issue(1, 0, 32'h0000_00FF, 16'h0010, 1);

    // Reset in the middle of a 16-bit division.
    issue(0, 0, 32'h0000_FFFF, 16'h0003, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_q = '0; last_r = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    repeat (25) @(negedge clk);
    issue(0, 0, 32'h0000_FFFF, 16'h0003, 1);

    for (int i = 0; i < 250; i++) begin
      is8 = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      dvd = $urandom;
      dvs = 16'($urandom);
      case ($urandom_range(0, 3))
        0: if ($urandom_range(0, 7) == 0) dvs = '0;
        1: dvd[31:20] = '0;
        2: begin dvd[15:12] = '0; dvs[7:6] = 2'b01; end
        default: dvd = {{16{dvd[15]}}, dvd[15:0]};
      endcase
      issue(is8, sgn, dvd, dvs, 1);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
